// File: rtl/accum_pkg.sv
// Shared constants and FSM state type for the accumulator read-out path.
package accum_pkg;

    localparam int ACCUM_ROW_DEF = 256;
    localparam int ACCUM_DATA_W  = 32;
    localparam int ACT_OUT_W     = 8;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        FLUSH,
        FIN
    } drain_state_e;

endpackage

// File: rtl/accum_requant.sv
// Combinational requantizer: round-half-up arithmetic shift, optional ReLU,
// saturation to a narrow signed word.
module accum_requant
    import accum_pkg::*;
#(
    parameter  int DATA_WIDTH  = ACCUM_DATA_W,
    parameter  int OUT_WIDTH   = ACT_OUT_W,
    localparam int SHIFT_WIDTH = $clog2(DATA_WIDTH)
) (
    input  logic signed [DATA_WIDTH-1:0]  x,
    input  logic        [SHIFT_WIDTH-1:0] shift,
    input  logic                          relu_en,
    output logic signed [OUT_WIDTH-1:0]   y
);

    localparam int XW = DATA_WIDTH + 1;
    localparam logic signed [XW-1:0] OUT_MAX = XW'((2 ** (OUT_WIDTH - 1)) - 1);
    localparam logic signed [XW-1:0] OUT_MIN = XW'(-(2 ** (OUT_WIDTH - 1)));

    logic signed [XW-1:0] xe;
    logic signed [XW-1:0] half;
    logic signed [XW-1:0] r;

    always_comb begin
        xe   = {x[DATA_WIDTH-1], x};
        // 2^(shift-1), which collapses to 0 when shift is 0
        half = (XW'(1) << shift) >> 1;
        r    = (xe + half) >>> shift;
        if (relu_en && r[XW-1]) begin
            r = '0;
        end
        if (r > OUT_MAX) begin
            y = OUT_MAX[OUT_WIDTH-1:0];
        end else if (r < OUT_MIN) begin
            y = OUT_MIN[OUT_WIDTH-1:0];
        end else begin
            y = r[OUT_WIDTH-1:0];
        end
    end

endmodule

// File: rtl/accum_drain.sv
// Accumulator column read-out: walks a wrapping row range, requantizes each
// row and streams the results over valid/ready.
module accum_drain
    import accum_pkg::*;
#(
    parameter  int ACCUM_ROW   = ACCUM_ROW_DEF,
    parameter  int DATA_WIDTH  = ACCUM_DATA_W,
    parameter  int OUT_WIDTH   = ACT_OUT_W,
    localparam int ADDR_WIDTH  = $clog2(ACCUM_ROW),
    localparam int SHIFT_WIDTH = $clog2(DATA_WIDTH)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic        [ADDR_WIDTH-1:0]  base_addr,
    input  logic        [ADDR_WIDTH:0]    num_rows,
    input  logic        [SHIFT_WIDTH-1:0] shift,
    input  logic                          relu_en,
    output logic                          busy,
    output logic                          done,
    output logic                          accum_rd_en,
    output logic        [ADDR_WIDTH-1:0]  accum_rd_addr,
    input  logic signed [DATA_WIDTH-1:0]  accum_rd_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic        [OUT_WIDTH-1:0]   out_data,
    output logic                          out_last
);

    drain_state_e                 state;
    logic [ADDR_WIDTH:0]          rows_left;
    logic [SHIFT_WIDTH-1:0]       shift_q;
    logic                         relu_q;
    logic signed [OUT_WIDTH-1:0]  rq_data;
    logic                         handshake;
    logic                         issue;
    logic                         last_row;
    logic [ADDR_WIDTH-1:0]        next_addr;

    assign handshake   = out_valid && out_ready;
    // Read data is combinational, so a read may be issued in the same cycle
    // the current output word is being taken.
    assign issue       = (state == READ) && (!out_valid || out_ready);
    assign last_row    = (rows_left == (ADDR_WIDTH + 1)'(1));
    assign accum_rd_en = issue;
    assign next_addr   = (accum_rd_addr == ADDR_WIDTH'(ACCUM_ROW - 1)) ? '0
                       : accum_rd_addr + ADDR_WIDTH'(1);

    accum_requant #(
        .DATA_WIDTH(DATA_WIDTH),
        .OUT_WIDTH (OUT_WIDTH)
    ) u_requant (
        .x      (accum_rd_data),
        .shift  (shift_q),
        .relu_en(relu_q),
        .y      (rq_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            busy          <= 1'b0;
            done          <= 1'b0;
            rows_left     <= '0;
            shift_q       <= '0;
            relu_q        <= 1'b0;
            accum_rd_addr <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        busy          <= 1'b1;
                        accum_rd_addr <= base_addr;
                        rows_left     <= num_rows;
                        shift_q       <= shift;
                        relu_q        <= relu_en;
                        if (num_rows == '0) begin
                            state <= FIN;
                            done  <= 1'b1;
                        end else begin
                            state <= READ;
                        end
                    end
                end
                READ: begin
                    if (issue) begin
                        accum_rd_addr <= next_addr;
                        rows_left     <= rows_left - (ADDR_WIDTH + 1)'(1);
                        if (last_row) begin
                            state <= FLUSH;
                        end
                    end
                end
                FLUSH: begin
                    if (handshake) begin
                        state <= FIN;
                        done  <= 1'b1;
                    end
                end
                FIN: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else if (issue) begin
            out_valid <= 1'b1;
            out_data  <= rq_data;
            out_last  <= last_row;
        end else if (handshake) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_accum_drain.sv
// Directed, table-driven bench for accum_drain with a behavioural column.
module tb_accum_drain;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic [7:0]         base_addr;
    logic [8:0]         num_rows;
    logic [4:0]         shift;
    logic               relu_en;
    logic               busy;
    logic               done;
    logic               accum_rd_en;
    logic [7:0]         accum_rd_addr;
    logic signed [31:0] accum_rd_data;
    logic               out_valid;
    logic               out_ready;
    logic [7:0]         out_data;
    logic               out_last;

    logic signed [31:0] mem [256];
    assign accum_rd_data = mem[accum_rd_addr];

    always #5 clk = ~clk;

    accum_drain #(
        .ACCUM_ROW (256),
        .DATA_WIDTH(32),
        .OUT_WIDTH (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .base_addr    (base_addr),
        .num_rows     (num_rows),
        .shift        (shift),
        .relu_en      (relu_en),
        .busy         (busy),
        .done         (done),
        .accum_rd_en  (accum_rd_en),
        .accum_rd_addr(accum_rd_addr),
        .accum_rd_data(accum_rd_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_last     (out_last)
    );

    typedef struct {
        int              base;
        int              num;
        int              sh;
        bit              relu;
        bit [3:0]        pat;
        bit              poke;
        int              exp_done;
        logic [0:5][31:0] rows;
        logic [0:5][7:0]  expv;
    } vec_t;

    vec_t vecs [8];
    int   total = 0;
    int   bad = 0;

    int   d_q [$];
    bit   l_q [$];
    int   rd_q [$];
    int   rel;
    int   done_cnt;
    int   done_rel;
    bit   busy_at_done;
    bit   prev_stall;
    logic [7:0] hold_data;
    bit   hold_last;

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One clock: sample and monitor at negedge, then return just after posedge.
    task automatic step();
        @(negedge clk);
        if (prev_stall) begin
            chk("stall_valid", out_valid, 1);
            chk("stall_data", out_data, hold_data);
            chk("stall_last", out_last, hold_last);
        end
        if (out_valid && !out_ready) chk("stall_no_read", accum_rd_en, 0);
        if (accum_rd_en) rd_q.push_back(int'(accum_rd_addr));
        if (out_valid && out_ready) begin
            d_q.push_back(int'($signed(out_data)));
            l_q.push_back(out_last);
        end
        if (done) begin
            done_cnt++;
            done_rel     = rel;
            busy_at_done = busy;
        end
        prev_stall = out_valid && !out_ready;
        hold_data  = out_data;
        hold_last  = out_last;
        rel++;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        d_q.delete();
        l_q.delete();
        rd_q.delete();
        done_cnt   = 0;
        done_rel   = -1;
        prev_stall = 0;
        rel        = 0;
    endtask

    task automatic run_job(input int idx);
        vec_t v;
        v = vecs[idx];
        for (int k = 0; k < v.num && k < 6; k++) mem[(v.base + k) % 256] = v.rows[k];
        clear_log();
        start     = 1'b1;
        base_addr = v.base[7:0];
        num_rows  = v.num[8:0];
        shift     = v.sh[4:0];
        relu_en   = v.relu;
        out_ready = v.pat[0];
        step();
        start     = 1'b0;
        base_addr = ~base_addr;
        num_rows  = 9'd3;
        shift     = ~shift;
        relu_en   = ~relu_en;
        while (done_cnt == 0 && rel < 300) begin
            out_ready = v.pat[rel % 4];
            if (v.poke && rel == 2) begin
                start     = 1'b1;
                base_addr = 8'd0;
                num_rows  = 9'd2;
            end else begin
                start = 1'b0;
            end
            step();
        end
        start = 1'b0;
        if (done_cnt == 0) chk($sformatf("v%0d_timeout", idx), 0, 1);
        @(negedge clk);
        chk($sformatf("v%0d_busy_after", idx), busy, 0);
        chk($sformatf("v%0d_done_after", idx), done, 0);
        @(posedge clk);
        #1;
        chk($sformatf("v%0d_nout", idx), d_q.size(), v.num);
        chk($sformatf("v%0d_nread", idx), rd_q.size(), v.num);
        for (int k = 0; k < v.num && k < d_q.size(); k++) begin
            chk($sformatf("v%0d_data%0d", idx, k), d_q[k], longint'($signed(v.expv[k])));
            chk($sformatf("v%0d_last%0d", idx, k), l_q[k], (k == v.num - 1) ? 1 : 0);
        end
        for (int k = 0; k < v.num && k < rd_q.size(); k++)
            chk($sformatf("v%0d_addr%0d", idx, k), rd_q[k], (v.base + k) % 256);
        chk($sformatf("v%0d_done_cnt", idx), done_cnt, 1);
        chk($sformatf("v%0d_busy_at_done", idx), busy_at_done, 1);
        if (v.exp_done >= 0) chk($sformatf("v%0d_done_cycle", idx), done_rel, v.exp_done);
    endtask

    task automatic set_vec(input int i, input int base, input int num, input int sh,
                           input bit relu, input bit [3:0] pat, input bit poke,
                           input int exp_done, input logic [0:5][31:0] rows,
                           input logic [0:5][7:0] expv);
        vecs[i].base     = base;
        vecs[i].num      = num;
        vecs[i].sh       = sh;
        vecs[i].relu     = relu;
        vecs[i].pat      = pat;
        vecs[i].poke     = poke;
        vecs[i].exp_done = exp_done;
        vecs[i].rows     = rows;
        vecs[i].expv     = expv;
    endtask

    initial begin
        set_vec(0, 0, 4, 2, 0, 4'b1111, 0, 6,
                {32'sd100, -32'sd100, 32'sd7, 32'sd0, 32'sd0, 32'sd0},
                {8'sd25, -8'sd25, 8'sd2, 8'sd0, 8'sd0, 8'sd0});
        set_vec(1, 254, 4, 0, 1, 4'b1111, 0, 6,
                {-32'sd8, 32'sd8, 32'sd3, -32'sd1, 32'sd0, 32'sd0},
                {8'sd0, 8'sd8, 8'sd3, 8'sd0, 8'sd0, 8'sd0});
        set_vec(2, 10, 4, 0, 0, 4'b1111, 0, 6,
                {32'sd1000, -32'sd1000, 32'sd127, -32'sd128, 32'sd0, 32'sd0},
                {8'sd127, 8'h80, 8'sd127, 8'h80, 8'sd0, 8'sd0});
        set_vec(3, 10, 4, 3, 0, 4'b1111, 0, 6,
                {32'sd1000, -32'sd1000, 32'sd127, -32'sd128, 32'sd0, 32'sd0},
                {8'sd125, -8'sd125, 8'sd16, -8'sd16, 8'sd0, 8'sd0});
        set_vec(4, 20, 5, 1, 0, 4'b1001, 0, -1,
                {32'sd10, -32'sd3, 32'sd5, -32'sd7, 32'sd255, 32'sd0},
                {8'sd5, -8'sd1, 8'sd3, -8'sd3, 8'sd127, 8'sd0});
        set_vec(5, 0, 0, 0, 0, 4'b1111, 0, 1,
                {32'sd0, 32'sd0, 32'sd0, 32'sd0, 32'sd0, 32'sd0},
                {8'sd0, 8'sd0, 8'sd0, 8'sd0, 8'sd0, 8'sd0});
        set_vec(6, 100, 2, 31, 0, 4'b1111, 0, 4,
                {32'h7fffffff, 32'h80000000, 32'sd0, 32'sd0, 32'sd0, 32'sd0},
                {8'sd1, -8'sd1, 8'sd0, 8'sd0, 8'sd0, 8'sd0});
        set_vec(7, 40, 4, 2, 0, 4'b1111, 1, 6,
                {32'sd100, -32'sd100, 32'sd7, 32'sd0, 32'sd0, 32'sd0},
                {8'sd25, -8'sd25, 8'sd2, 8'sd0, 8'sd0, 8'sd0});

        for (int i = 0; i < 256; i++) mem[i] = 32'(i * 3 + 1);
        rst = 1'b1; start = 1'b0; base_addr = '0; num_rows = '0;
        shift = '0; relu_en = 1'b0; out_ready = 1'b1;
        clear_log();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_rd_en", accum_rd_en, 0);
        chk("reset_addr", accum_rd_addr, 0);
        chk("reset_valid", out_valid, 0);
        chk("reset_data", out_data, 0);
        chk("reset_last", out_last, 0);
        @(posedge clk);
        #1;

        for (int i = 0; i < 8; i++) run_job(i);

        // Reset after the second output of a six-row run.
        for (int k = 0; k < 6; k++) mem[60 + k] = 32'((k + 1) * 8);
        clear_log();
        start = 1'b1; base_addr = 8'd60; num_rows = 9'd6; shift = 5'd3;
        relu_en = 1'b0; out_ready = 1'b1;
        step();
        start = 1'b0;
        while (d_q.size() < 2 && rel < 50) step();
        chk("rst_run_pre_outputs", d_q.size(), 2);
        if (d_q.size() >= 2) begin
            chk("rst_run_d0", d_q[0], 1);
            chk("rst_run_d1", d_q[1], 2);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        prev_stall = 0;
        @(negedge clk);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_done", done, 0);
        chk("rst_mid_rd_en", accum_rd_en, 0);
        chk("rst_mid_addr", accum_rd_addr, 0);
        chk("rst_mid_valid", out_valid, 0);
        chk("rst_mid_data", out_data, 0);
        chk("rst_mid_last", out_last, 0);
        @(posedge clk);
        #1;
        clear_log();
        repeat (8) step();
        chk("rst_idle_done", done_cnt, 0);
        chk("rst_idle_out", d_q.size(), 0);
        chk("rst_idle_read", rd_q.size(), 0);
        run_job(0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
